// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and flow-control unit for the IF/ID/EX/WB pipeline. It produces
//   stall/flush/freeze/forwarding controls from the stage-tagged register
//   addresses. It also runs a data-memory wait FSM with a timeout, and keeps
//   saturating stall and flush event counters.
//
//   Build option: define HAZARD_FWD_EN to enable WB->EX and WB->ID
//   forwarding. In that build the RAW stall is never raised. When it is
//   undefined, the fwd outputs are tied low and RAW hazards against EX/WB
//   stall the front end.
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   rs1_id, rs2_id       ID source registers; use_rs*_id marks real reads
//   rs1_ex, rs2_ex       EX source registers
//   rd_ex, reg_write_ex  EX destination / write enable
//   rd_wb, reg_write_wb  WB destination / write enable
//   branch_taken_ex      taken branch resolved in EX
//   dmem_req_ex          EX instruction accesses data memory
//   dmem_ready           data memory completes the access this cycle
//   stall_if, stall_id   hold PC / IF-ID
//   flush_id, flush_ex   clear IF-ID / ID-EX
//   freeze               hold every pipeline register
//   fwd_ex_a/b           EX operand takes the WB result
//   fwd_id_a/b           ID read data takes the WB result
//   mem_err              one-cycle pulse when an access is abandoned
//   stall_cnt, flush_cnt saturating event counters
//
// FSM states
//   ST_RUN   | no outstanding memory wait
//   ST_WAIT  | access stalled; wait_cnt counts the frozen cycles
//   ST_ABORT | one cycle after a timeout; the abandoned access is dropped

module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             use_rs1_id,
  input  logic             use_rs2_id,
  input  logic [4:0]       rs1_ex,
  input  logic [4:0]       rs2_ex,
  input  logic [4:0]       rd_ex,
  input  logic             reg_write_ex,
  input  logic [4:0]       rd_wb,
  input  logic             reg_write_wb,
  input  logic             branch_taken_ex,
  input  logic             dmem_req_ex,
  input  logic             dmem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             freeze,
  output logic             fwd_ex_a,
  output logic             fwd_ex_b,
  output logic             fwd_id_a,
  output logic             fwd_id_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic mem_pending;
  logic timeout_hit;
  logic raw_stall;
  logic fwd_ex_a_m, fwd_ex_b_m, fwd_id_a_m, fwd_id_b_m;

  assign mem_pending = dmem_req_ex & ~dmem_ready;
  // Masked by reset so a reset landing on the timeout cycle never pulses mem_err.
  assign timeout_hit = ~reset & (state_q == ST_WAIT) &
                       (wait_cnt_q == WCW'(MEM_TIMEOUT));

`ifdef HAZARD_FWD_EN
  logic wb_fwd_ok;
  logic unused_fwd;
  assign wb_fwd_ok  = reg_write_wb & (rd_wb != 5'd0);
  assign fwd_ex_a_m = wb_fwd_ok & (rd_wb == rs1_ex);
  assign fwd_ex_b_m = wb_fwd_ok & (rd_wb == rs2_ex);
  // The register file has no write bypass, so ID also needs the WB value.
  assign fwd_id_a_m = wb_fwd_ok & (rd_wb == rs1_id);
  assign fwd_id_b_m = wb_fwd_ok & (rd_wb == rs2_id);
  assign raw_stall  = 1'b0;
  assign unused_fwd = ^{use_rs1_id, use_rs2_id, rd_ex, reg_write_ex};
`else
  logic hit_rs1, hit_rs2;
  logic unused_fwd;
  assign hit_rs1 = use_rs1_id & (rs1_id != 5'd0) &
                   ((reg_write_ex & (rd_ex == rs1_id)) |
                    (reg_write_wb & (rd_wb == rs1_id)));
  assign hit_rs2 = use_rs2_id & (rs2_id != 5'd0) &
                   ((reg_write_ex & (rd_ex == rs2_id)) |
                    (reg_write_wb & (rd_wb == rs2_id)));
  assign raw_stall  = hit_rs1 | hit_rs2;
  assign fwd_ex_a_m = 1'b0;
  assign fwd_ex_b_m = 1'b0;
  assign fwd_id_a_m = 1'b0;
  assign fwd_id_b_m = 1'b0;
  assign unused_fwd = ^{rs1_ex, rs2_ex};
`endif

  // Next state for the memory-wait FSM
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (mem_pending) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WCW'(1);
        end
      end
      ST_WAIT: begin
        if (timeout_hit) begin
          state_d    = ST_ABORT;
          wait_cnt_d = '0;
        end else if (dmem_ready || !dmem_req_ex) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      ST_ABORT: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Pipeline controls; priority is reset > freeze > branch flush > RAW stall
  always_comb begin
    stall_if = 1'b0;
    stall_id = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    freeze   = 1'b0;
    fwd_id_a = 1'b0;
    fwd_id_b = 1'b0;
    fwd_ex_a = ~reset & fwd_ex_a_m;
    fwd_ex_b = ~reset & fwd_ex_b_m;
    mem_err  = timeout_hit;
    if (!reset) begin
      if (mem_pending && !timeout_hit) begin
        freeze = 1'b1;
      end else begin
        fwd_id_a = fwd_id_a_m;
        fwd_id_b = fwd_id_b_m;
        if (branch_taken_ex) begin
          flush_id = 1'b1;
          flush_ex = 1'b1;
        end else if (raw_stall) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
        end
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((stall_id || freeze) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_id && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).

module tb_pipeline_hazard_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // {stall_if, stall_id, flush_id, flush_ex, freeze,
  //  fwd_ex_a, fwd_ex_b, fwd_id_a, fwd_id_b, mem_err}
  localparam logic [9:0] O_NONE  = 10'b00000_00000;
  localparam logic [9:0] O_STALL = 10'b11010_00000;
  localparam logic [9:0] O_FLUSH = 10'b00110_00000;
  localparam logic [9:0] O_FRZ   = 10'b00001_00000;
  localparam logic [9:0] O_ERR   = 10'b00000_00001;
  localparam logic [9:0] O_FWD5  = 10'b00000_10010;
  localparam logic [9:0] O_FIDA  = 10'b00000_00100;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_wb;
  logic use_rs1_id, use_rs2_id, reg_write_ex, reg_write_wb;
  logic branch_taken_ex, dmem_req_ex, dmem_ready;
  logic stall_if, stall_id, flush_id, flush_ex, freeze;
  logic fwd_ex_a, fwd_ex_b, fwd_id_a, fwd_id_b, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [9:0] outs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
    .rd_ex(rd_ex), .reg_write_ex(reg_write_ex),
    .rd_wb(rd_wb), .reg_write_wb(reg_write_wb),
    .branch_taken_ex(branch_taken_ex),
    .dmem_req_ex(dmem_req_ex), .dmem_ready(dmem_ready),
    .stall_if(stall_if), .stall_id(stall_id),
    .flush_id(flush_id), .flush_ex(flush_ex), .freeze(freeze),
    .fwd_ex_a(fwd_ex_a), .fwd_ex_b(fwd_ex_b),
    .fwd_id_a(fwd_id_a), .fwd_id_b(fwd_id_b),
    .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign outs = {stall_if, stall_id, flush_id, flush_ex, freeze,
                 fwd_ex_a, fwd_ex_b, fwd_id_a, fwd_id_b, mem_err};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_o(input string tag, input logic [9:0] exp);
    #1;
    chk(tag, {22'd0, outs}, {22'd0, exp});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1_id = 0; rs2_id = 0; rs1_ex = 0; rs2_ex = 0; rd_ex = 0; rd_wb = 0;
    use_rs1_id = 0; use_rs2_id = 0; reg_write_ex = 0; reg_write_wb = 0;
    branch_taken_ex = 0; dmem_req_ex = 0; dmem_ready = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic set_raw_ex3();
    rs1_id = 5'd3; use_rs1_id = 1'b1; rd_ex = 5'd3; reg_write_ex = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    // reset dominates even with freeze and branch requests present
    idle();
    reset = 1'b1;
    dmem_req_ex = 1'b1;
    branch_taken_ex = 1'b1;
    cyc();
    chk_o("in_reset", O_NONE);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      chk_o("idle_outs", O_NONE);
      chk("idle_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("idle_flush_cnt", 32'(flush_cnt), 32'd0);
      cyc();
    end

    // WB forwarding, then rd_wb = x0
    rd_wb = 5'd5; reg_write_wb = 1'b1; rs1_ex = 5'd5; rs2_id = 5'd5; use_rs2_id = 1'b1;
    chk_o("fwd_wb5", FWD ? O_FWD5 : O_STALL);
    rd_wb = 5'd0;
    chk_o("fwd_x0", O_NONE);
    cyc();

    // RAW against EX, producer moves to WB, then clears
    do_reset();
    set_raw_ex3();
    chk_o("raw_ex", FWD ? O_NONE : O_STALL);
    cyc();
    rd_ex = 5'd0; reg_write_ex = 1'b0; rd_wb = 5'd3; reg_write_wb = 1'b1;
    chk_o("raw_wb", FWD ? O_FIDA : O_STALL);
    cyc();
    rd_wb = 5'd0; reg_write_wb = 1'b0;
    chk_o("raw_clear", O_NONE);
    chk("raw_stall_cnt", 32'(stall_cnt), FWD ? 32'd0 : 32'd2);
    set_raw_ex3(); use_rs1_id = 1'b0;
    chk_o("raw_unused_src", O_NONE);
    use_rs1_id = 1'b1; reg_write_ex = 1'b0;
    chk_o("raw_no_write", O_NONE);
    reg_write_ex = 1'b1; rs1_id = 5'd0; rd_ex = 5'd0;
    chk_o("raw_x0", O_NONE);
    cyc();
    chk("raw_stall_cnt_hold", 32'(stall_cnt), FWD ? 32'd0 : 32'd2);

    // branch flush beats a simultaneous RAW stall
    do_reset();
    set_raw_ex3();
    branch_taken_ex = 1'b1;
    chk_o("br_over_raw", O_FLUSH);
    cyc();
    idle();
    chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("br_stall_cnt", 32'(stall_cnt), 32'd0);

    // memory wait of 3 cycles; freeze masks branch and RAW
    do_reset();
    dmem_req_ex = 1'b1; dmem_ready = 1'b0;
    chk_o("mw_c0", O_FRZ);
    cyc();
    branch_taken_ex = 1'b1;
    chk_o("mw_c1_branch", O_FRZ);
    cyc();
    branch_taken_ex = 1'b0;
    rs1_id = 5'd7; use_rs1_id = 1'b1; rd_wb = 5'd7; reg_write_wb = 1'b1;
    chk_o("mw_c2_raw", O_FRZ);
    cyc();
    idle();
    dmem_req_ex = 1'b1; dmem_ready = 1'b1;
    chk_o("mw_c3_ready", O_NONE);
    cyc();
    idle();
    chk("mw_stall_cnt", 32'(stall_cnt), 32'd3);
    chk("mw_flush_cnt", 32'(flush_cnt), 32'd0);

    // timeout: freeze cycles 0..3, mem_err in cycle 4, ABORT, then a fresh access
    do_reset();
    dmem_req_ex = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < TO; i++) begin
      chk_o($sformatf("to_frz_c%0d", i), O_FRZ);
      cyc();
    end
    chk_o("to_err", O_ERR);
    cyc();
    dmem_req_ex = 1'b0;
    chk_o("to_abort", O_NONE);
    cyc();
    dmem_req_ex = 1'b1;
    for (int i = 0; i < TO; i++) begin
      chk_o($sformatf("to2_frz_c%0d", i), O_FRZ);
      cyc();
    end
    chk_o("to2_err", O_ERR);
    cyc();
    idle();
    chk("to_stall_cnt", 32'(stall_cnt), 32'd8);

    // reset on the timeout cycle: no mem_err, next access starts fresh
    do_reset();
    dmem_req_ex = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < TO; i++) begin
      chk_o($sformatf("rw_frz_c%0d", i), O_FRZ);
      cyc();
    end
    reset = 1'b1;
    chk_o("rw_reset_no_err", O_NONE);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < TO; i++) begin
      chk_o($sformatf("rw_after_c%0d", i), O_FRZ);
      cyc();
    end
    chk_o("rw_err", O_ERR);
    cyc();
    idle();
    chk("rw_stall_cnt", 32'(stall_cnt), 32'd4);

    // counter saturation at all-ones
    do_reset();
    branch_taken_ex = 1'b1;
    for (int i = 0; i < 18; i++) cyc();
    branch_taken_ex = 1'b0;
    chk("sat_flush_cnt", 32'(flush_cnt), 32'd15);
    set_raw_ex3();
    for (int i = 0; i < 18; i++) cyc();
    idle();
    chk("sat_stall_cnt", 32'(stall_cnt), FWD ? 32'd0 : 32'd15);
    chk("sat_flush_hold", 32'(flush_cnt), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
